// File: rtl/mic_pdm_receiver.sv
// PDM microphone front end: drives M_CLK, counts ones over 128-bit windows, reports sample/magnitude/loud.
// Optional macro MIC_LOUD_HOLD_EN stretches loud for HOLD_CYCLES; otherwise loud is a one-cycle pulse.
module mic_pdm_receiver #(
    parameter int CLK_DIV     = 20,
    parameter int HOLD_CYCLES = 10000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       enable,
    input  logic [6:0] threshold,
    input  logic       M_DATA,
    output logic       M_CLK,
    output logic       M_LR_SEL,
    output logic [7:0] sample,
    output logic [6:0] magnitude,
    output logic       sample_valid,
    output logic       loud
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("mic_pdm_receiver: CLK_DIV must be 2..255 and HOLD_CYCLES at least 1");
    end

    function automatic logic [6:0] dist_from_mid(input logic [7:0] v);
        if (v >= 8'd64) begin
            return 7'(v - 8'd64);
        end else begin
            return 7'(8'd64 - v);
        end
    endfunction

    logic [1:0] data_sync_r;
    state_t     state_r;
    logic [7:0] div_cnt_r;
    logic       mclk_r;
    logic [6:0] bit_cnt_r;
    logic [7:0] ones_r;
    logic [1:0] warm_cnt_r;
    logic [7:0] sample_r;
    logic [6:0] mag_r;
    logic       valid_r;
    logic       loud_r;

    logic       div_wrap_s;
    logic       capture_s;
    logic       window_done_s;
    logic [7:0] window_sum_s;
    logic [6:0] window_mag_s;
    logic       trip_s;

    // Divider wrap, capture strobe on the falling M_CLK edge, and window-completion arithmetic.
    always_comb begin
        div_wrap_s    = (div_cnt_r == DIV_LAST);
        capture_s     = div_wrap_s && mclk_r;
        window_done_s = capture_s && (bit_cnt_r == 7'd127);
        window_sum_s  = ones_r + {7'd0, data_sync_r[1]};
        window_mag_s  = dist_from_mid(window_sum_s);
        trip_s        = window_done_s && (state_r == RUN) && (threshold != 7'd0)
                        && (window_mag_s >= threshold);
    end

    // Two-flop synchronizer for the asynchronous PDM input.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            data_sync_r <= 2'b00;
        end else begin
            data_sync_r <= {data_sync_r[0], M_DATA};
        end
    end

    // Control FSM, clock divider, window accumulation and registered sample outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_r    <= IDLE;
            div_cnt_r  <= 8'd0;
            mclk_r     <= 1'b0;
            bit_cnt_r  <= 7'd0;
            ones_r     <= 8'd0;
            warm_cnt_r <= 2'd0;
            sample_r   <= 8'd0;
            mag_r      <= 7'd0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!enable) begin
                // Parking discards any partial window but keeps the last sample.
                state_r    <= IDLE;
                div_cnt_r  <= 8'd0;
                mclk_r     <= 1'b0;
                bit_cnt_r  <= 7'd0;
                ones_r     <= 8'd0;
                warm_cnt_r <= 2'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r    <= WARMUP;
                        div_cnt_r  <= 8'd0;
                        mclk_r     <= 1'b0;
                        bit_cnt_r  <= 7'd0;
                        ones_r     <= 8'd0;
                        warm_cnt_r <= 2'd0;
                    end
                    WARMUP, RUN: begin
                        div_cnt_r <= div_wrap_s ? 8'd0 : div_cnt_r + 8'd1;
                        if (div_wrap_s) begin
                            mclk_r <= ~mclk_r;
                        end else begin
                            mclk_r <= mclk_r;
                        end
                        if (window_done_s) begin
                            bit_cnt_r <= 7'd0;
                            ones_r    <= 8'd0;
                            if (state_r == RUN) begin
                                sample_r <= window_sum_s;
                                mag_r    <= window_mag_s;
                                valid_r  <= 1'b1;
                            end else if (warm_cnt_r == 2'd3) begin
                                state_r    <= RUN;
                                warm_cnt_r <= 2'd0;
                            end else begin
                                warm_cnt_r <= warm_cnt_r + 2'd1;
                            end
                        end else if (capture_s) begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                            ones_r    <= window_sum_s;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                            ones_r    <= ones_r;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        div_cnt_r  <= 8'd0;
                        mclk_r     <= 1'b0;
                        bit_cnt_r  <= 7'd0;
                        ones_r     <= 8'd0;
                        warm_cnt_r <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef MIC_LOUD_HOLD_EN
    localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_r;

    // Loud stretch: each trip reloads the hold so loud stays high HOLD_CYCLES cycles.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            loud_r     <= 1'b0;
            hold_cnt_r <= '0;
        end else if (!enable) begin
            loud_r     <= 1'b0;
            hold_cnt_r <= '0;
        end else if (trip_s) begin
            loud_r     <= 1'b1;
            hold_cnt_r <= HOLD_RELOAD;
        end else if (hold_cnt_r != '0) begin
            loud_r     <= loud_r;
            hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
        end else begin
            loud_r     <= 1'b0;
            hold_cnt_r <= '0;
        end
    end
`else
    // Loud pulse coincident with the tripping sample_valid.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            loud_r <= 1'b0;
        end else begin
            loud_r <= enable && trip_s;
        end
    end
`endif

    assign M_CLK        = mclk_r;
    assign M_LR_SEL     = 1'b0;
    assign sample       = sample_r;
    assign magnitude    = mag_r;
    assign sample_valid = valid_r;
    assign loud         = loud_r;

endmodule

// File: tb/tb_mic_pdm_receiver.sv
// Self-checking bench for mic_pdm_receiver: directed window table plus randomized PDM windows
// compared against a window-level ones-count model; covers warmup, enable drop and async reset.
module tb_mic_pdm_receiver;

    localparam int CLK_DIV     = 10;
    localparam int HOLD_CYCLES = 1000;
    localparam int WIN_CYC     = 256 * CLK_DIV;
    localparam int FIRST_SV    = 1 + 5 * WIN_CYC;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN;
    logic       enable;
    logic [6:0] threshold;
    logic       M_DATA;
    logic       M_CLK;
    logic       M_LR_SEL;
    logic [7:0] sample;
    logic [6:0] magnitude;
    logic       sample_valid;
    logic       loud;

    always #5 CLK100MHZ = ~CLK100MHZ;

    mic_pdm_receiver #(
        .CLK_DIV     (CLK_DIV),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESETN   (CPU_RESETN),
        .enable       (enable),
        .threshold    (threshold),
        .M_DATA       (M_DATA),
        .M_CLK        (M_CLK),
        .M_LR_SEL     (M_LR_SEL),
        .sample       (sample),
        .magnitude    (magnitude),
        .sample_valid (sample_valid),
        .loud         (loud)
    );

    // mode: 0 all ones, 1 all zeros, 2 alternating, 3 random with density dens%
    typedef struct {
        int mode;
        int dens;
        int thr;
        bit directed;
        int exp_sample;
        int exp_mag;
        bit exp_loud;
    } vec_t;

    vec_t vecs [0:11];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cyc0 = 0;
    bit   active = 0;
    int   n_bits = 0;
    int   cur_sum = 0;
    vec_t cur_vec;
    int   vec_base = 0;
    int   vec_cnt = 0;
    bit   pend_valid = 0;
    int   pend_due = 0;
    int   pend_sample = 0;
    int   pend_mag = 0;
    bit   pend_loud = 0;
    int   last_sample = 0;
    int   last_mag = 0;
    int   hold_left = 0;
    bit   mclk_prev = 0;
    int   first_sv = -1;
    int   rise_rel [0:1];
    int   rise_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t run_vec(input int k);
        vec_t v;
        if (k < vec_cnt) begin
            v = vecs[vec_base + k];
        end else begin
            v.mode = 3; v.dens = 50; v.thr = 0; v.directed = 0;
            v.exp_sample = 0; v.exp_mag = 0; v.exp_loud = 0;
        end
        return v;
    endfunction

    task automatic model_start();
        active = 1; n_bits = 0; cur_sum = 0; pend_valid = 0;
        cyc0 = cyc; first_sv = -1;
    endtask

    task automatic model_stop();
        active = 0; n_bits = 0; cur_sum = 0; pend_valid = 0; hold_left = 0;
    endtask

    // One clock: compare outputs against the model, then drive the next PDM bit on an M_CLK rise.
    task automatic step();
        bit trip;
        bit b;
        int w;
        int mag;
        @(posedge CLK100MHZ);
        #1;
        cyc++;
        trip = 0;
        if (sample_valid && first_sv < 0) first_sv = cyc - cyc0;
        if (pend_valid && cyc == pend_due) begin
            pend_valid  = 0;
            last_sample = pend_sample;
            last_mag    = pend_mag;
            trip        = pend_loud;
            chk("sample_valid_pulse", sample_valid, 1);
        end else begin
            chk("sample_valid_quiet", sample_valid, 0);
        end
        chk("sample", sample, last_sample);
        chk("magnitude", magnitude, last_mag);
`ifdef MIC_LOUD_HOLD_EN
        if (trip) hold_left = HOLD_CYCLES;
        chk("loud", loud, int'(hold_left > 0));
        if (hold_left > 0) hold_left--;
`else
        chk("loud", loud, trip);
`endif
        chk("M_LR_SEL", M_LR_SEL, 0);
        if (!active) chk("M_CLK_parked", M_CLK, 0);
        if (active && M_CLK && !mclk_prev) begin
            if (rise_cnt < 2) begin
                rise_rel[rise_cnt] = cyc - cyc0;
                rise_cnt++;
            end
            w = n_bits / 128;
            if (n_bits % 128 == 0) begin
                if (w >= 4) begin
                    cur_vec = run_vec(w - 4);
                end else begin
                    cur_vec.mode = 3; cur_vec.dens = 50; cur_vec.directed = 0;
                    cur_vec.thr = $urandom_range(0, 64);
                end
                threshold = 7'(cur_vec.thr);
                cur_sum = 0;
            end
            case (cur_vec.mode)
                0:       b = 1'b1;
                1:       b = 1'b0;
                2:       b = (n_bits % 2 == 0);
                default: b = ($urandom_range(0, 99) < cur_vec.dens);
            endcase
            M_DATA  = b;
            cur_sum = cur_sum + int'(b);
            if (n_bits % 128 == 127 && w >= 4) begin
                pend_valid = 1;
                pend_due   = cyc + CLK_DIV;
                if (cur_vec.directed) begin
                    pend_sample = cur_vec.exp_sample;
                    pend_mag    = cur_vec.exp_mag;
                    pend_loud   = cur_vec.exp_loud;
                end else begin
                    mag         = (cur_sum >= 64) ? cur_sum - 64 : 64 - cur_sum;
                    pend_sample = cur_sum;
                    pend_mag    = mag;
                    pend_loud   = (cur_vec.thr != 0) && (mag >= cur_vec.thr);
                end
            end
            n_bits++;
        end
        mclk_prev = M_CLK;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 40, 1, 128, 64, 1};
        vecs[1]  = '{1, 0, 40, 1,   0, 64, 1};
        vecs[2]  = '{2, 0, 64, 1,  64,  0, 0};
        vecs[3]  = '{2, 0,  1, 1,  64,  0, 0};
        vecs[4]  = '{0, 0,  0, 1, 128, 64, 0};
        vecs[5]  = '{0, 0, 64, 1, 128, 64, 1};
        for (int i = 6; i < 10; i++) begin
            vecs[i] = '{3, int'($urandom_range(0, 100)), int'($urandom_range(1, 40)), 0, 0, 0, 0};
        end
        vecs[10] = '{0, 0, 40, 1, 128, 64, 1};
        vecs[11] = '{1, 0, 30, 1,   0, 64, 1};

        CPU_RESETN = 1'b0;
        enable     = 1'b0;
        threshold  = 7'd0;
        M_DATA     = 1'b0;
        #3;
        chk("reset_sample", sample, 0);
        chk("reset_magnitude", magnitude, 0);
        chk("reset_sample_valid", sample_valid, 0);
        chk("reset_loud", loud, 0);
        chk("reset_M_CLK", M_CLK, 0);
        chk("reset_M_LR_SEL", M_LR_SEL, 0);
        repeat (3) step();

        // Phase 1: warmup, directed table, random windows
        enable     = 1'b1;
        CPU_RESETN = 1'b1;
        vec_base   = 0;
        vec_cnt    = 10;
        model_start();
        repeat (FIRST_SV + 9 * WIN_CYC + 1500) step();
        chk("first_sample_valid_cycle", first_sv, FIRST_SV);
        chk("first_M_CLK_rise", rise_rel[0], 1 + CLK_DIV);
        chk("M_CLK_period", rise_rel[1] - rise_rel[0], 2 * CLK_DIV);

        // Phase 2: park mid-window, then re-enable and sit through a fresh warmup
        enable = 1'b0;
        model_stop();
        repeat (40) step();
        enable   = 1'b1;
        vec_base = 10;
        vec_cnt  = 1;
        model_start();
        repeat (FIRST_SV) step();
        chk("reenable_first_sample_valid", first_sv, FIRST_SV);
        chk("loud_before_reset", loud, 1);

        // Phase 3: asynchronous reset while loud is high
        #2;
        CPU_RESETN = 1'b0;
        #1;
        chk("async_sample", sample, 0);
        chk("async_magnitude", magnitude, 0);
        chk("async_sample_valid", sample_valid, 0);
        chk("async_loud", loud, 0);
        chk("async_M_CLK", M_CLK, 0);
        model_stop();
        last_sample = 0;
        last_mag    = 0;
        repeat (5) step();
        CPU_RESETN = 1'b1;
        vec_base   = 11;
        vec_cnt    = 1;
        model_start();
        repeat (FIRST_SV + 50) step();
        chk("post_reset_first_sample_valid", first_sv, FIRST_SV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_pdm_receiver.md
MIC_PDM_RECEIVER -- requirements
Module: mic_pdm_receiver

Interface
REQ-001 Parameter CLK_DIV, default 20, meaning CLK100MHZ cycles per M_CLK half-period; legal range 2..255.
REQ-002 Parameter HOLD_CYCLES, default 10000000, meaning loud hold time in CLK100MHZ cycles; used only with MIC_LOUD_HOLD_EN.
REQ-003 Port CLK100MHZ, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 Port CPU_RESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port enable, input, 1 bit: 1 runs the microphone, 0 parks the block.
REQ-006 Port threshold, input, 7 bits: loudness trip level 0..64; 0 disables loud.
REQ-007 Port M_DATA, input, 1 bit: PDM bitstream from the microphone, asynchronous to CLK100MHZ.
REQ-008 Port M_CLK, output, 1 bit: microphone clock, registered.
REQ-009 Port M_LR_SEL, output, 1 bit: channel select, constant 0.
REQ-010 Port sample, output, 8 bits: ones-count of the last completed 128-bit window, 0..128.
REQ-011 Port magnitude, output, 7 bits: |sample - 64|, 0..64.
REQ-012 Port sample_valid, output, 1 bit: one-cycle pulse when sample and magnitude update.
REQ-013 Port loud, output, 1 bit: loudness detect for the game (jump trigger).

Function
REQ-014 M_DATA SHALL pass a two-flop synchronizer before any use.
REQ-015 The divider SHALL count 0..CLK_DIV-1; M_CLK SHALL toggle on the cycle the count is CLK_DIV-1 and the count SHALL then wrap to 0, giving a period of 2*CLK_DIV cycles (40 cycles, 2.5 MHz at default).
REQ-016 One PDM bit SHALL be captured from the synchronized M_DATA on each cycle in which M_CLK toggles 1->0.
REQ-017 A bit counter (7 bits) and a ones accumulator (8 bits) SHALL track the window; the accumulator SHALL never exceed 128.
REQ-018 On the 128th captured bit, sample SHALL load the accumulator including that bit, magnitude SHALL load |that value - 64| in the same cycle, sample_valid SHALL pulse that same cycle, and both counters SHALL clear with no bit lost.
REQ-019 Window period SHALL be 128*2*CLK_DIV cycles (5120 at default).
REQ-020 The FSM SHALL have states IDLE, WARMUP and RUN.
REQ-021 IDLE: M_CLK held 0, divider and window counters held at 0, sample_valid 0; enable=1 moves the FSM to WARMUP on the next cycle.
REQ-022 WARMUP: the clock runs and windows accumulate, but sample, magnitude and sample_valid are not updated; after 4 completed windows the FSM moves to RUN.
REQ-023 RUN: every completed window updates the outputs per REQ-018.
REQ-024 enable=0 in any state SHALL force IDLE on the next cycle; a partial window SHALL be discarded; sample and magnitude SHALL keep their last values.
REQ-025 A window qualifies as a trip when it completes in RUN, threshold != 0, and the new magnitude >= threshold.
REQ-026 loud SHALL be cleared on entry to IDLE.

Reset
REQ-027 While CPU_RESETN=0, all of the following SHALL hold regardless of clock: FSM=IDLE, M_CLK=0, M_LR_SEL=0, sample=0, magnitude=0, sample_valid=0, loud=0, and all counters at 0.
REQ-028 Reset asserted mid-window SHALL discard the window; after release, operation SHALL restart from IDLE including the full WARMUP.

Configuration
REQ-029 Macro MIC_LOUD_HOLD_EN defined: loud SHALL rise on the trip cycle and stay high for HOLD_CYCLES cycles; each new trip SHALL reload the hold counter to HOLD_CYCLES.
REQ-030 MIC_LOUD_HOLD_EN undefined: loud SHALL be a one-cycle pulse coincident with the tripping sample_valid; no hold counter SHALL be built.

Verification
REQ-031 Release reset with enable=1 and CLK_DIV=20 -> M_CLK period 40 cycles; no sample_valid for the first 4 windows (20480 cycles); first pulse on window 5.
REQ-032 M_DATA constant 1, threshold=40 -> sample=128, magnitude=64, loud asserted; with M_DATA constant 0 -> sample=0, magnitude=64.
REQ-033 M_DATA alternating 1/0 per M_CLK -> sample=64, magnitude=0, loud stays 0 for any threshold 1..64; threshold=0 with all-ones input -> loud stays 0.
REQ-034 Drop enable mid-window in RUN -> M_CLK=0 next cycle, no sample_valid, sample holds; re-enable -> WARMUP repeats (4 windows discarded).
REQ-035 Assert CPU_RESETN=0 mid-window with loud high -> all outputs 0 immediately (asynchronously); after release, the full WARMUP repeats.
REQ-036 With MIC_LOUD_HOLD_EN and HOLD_CYCLES=1000: one tripping window -> loud high exactly 1000 cycles; without the macro -> loud high exactly 1 cycle, aligned with sample_valid.
